// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/FullSubtractor.sv
// One-bit full subtractor: diff = a - b - b_in, b_out set when a < b + b_in.
// Purely combinational.
module FullSubtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = a ^ b ^ b_in;
  assign b_out = (~a & (b | b_in)) | (b & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - b_in over WIDTH cycles, LSB first, through one FullSubtractor cell.
// Build with SERIAL_SUB_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sres;
  logic [WIDTH-1:0] r_diff;
  logic             r_brw;
  logic             r_bout;
  logic             r_done;
  logic [CW-1:0]    r_cnt;
  logic             w_cell_diff;
  logic             w_cell_bout;
  logic             w_accept;
  logic             w_last;

  FullSubtractor u_cell (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .b_in (r_brw),
    .diff (w_cell_diff),
    .b_out(w_cell_bout)
  );

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_sres <= '0;
      r_diff <= '0;
      r_brw  <= 1'b0;
      r_bout <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_sa  <= a;
        r_sb  <= b;
        r_brw <= b_in;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        // Result bits arrive LSB first, so they enter at the top and shift down.
        r_sres <= {w_cell_diff, r_sres[WIDTH-1:1]};
        r_sa   <= {1'b0, r_sa[WIDTH-1:1]};
        r_sb   <= {1'b0, r_sb[WIDTH-1:1]};
        r_brw  <= w_cell_bout;
        r_cnt  <= r_cnt + CW'(1);
        if (w_last) begin
          r_diff <= {w_cell_diff, r_sres[WIDTH-1:1]};
          r_bout <= w_cell_bout;
          r_done <= 1'b1;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
      end
      // On the last step the cell's diff is the result MSB.
      if (w_last) r_ovf <= (r_a_msb != r_b_msb) && (w_cell_diff != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy  = (r_state == RUN);
  assign done  = r_done;
  assign diff  = r_diff;
  assign b_out = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH=8) against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] held_diff;
  logic         held_bout;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .b_in (b_in),
    .busy (busy),
    .done (done),
    .diff (diff),
    .b_out(b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on whole operands.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    longint ia = longint'(ta);
    longint ib = longint'(tb_v);
    longint ic = longint'(tbin);
    longint r  = ia - ib - ic;
    ed = W'(r & ((longint'(1) << W) - 1));
    eb = (ia < ib + ic);
    eo = (ta[W-1] != tb_v[W-1]) && (ed[W-1] != ta[W-1]);
  endtask

  // Starts an op in the current cycle and returns in the cycle done is high.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input int repulse_at, input string tag);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    int           n;
    model(ta, tb_v, tbin, ed, eb, eo);
    a = ta; b = tb_v; b_in = tbin; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (done !== 1'b1 && n < 3 * W) begin
      chk({tag, " busy"}, 64'(busy), 64'(1));
      chk({tag, " hold"}, 64'({b_out, diff}), 64'({held_bout, held_diff}));
      a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
      if (n == repulse_at) begin
        start = 1'b1;
        a = 8'hAA;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'(W));
    chk({tag, " busy_end"}, 64'(busy), 64'(0));
    chk({tag, " diff"}, 64'(diff), 64'(ed));
    chk({tag, " b_out"}, 64'(b_out), 64'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, " ovf"}, 64'(ovf), 64'(eo));
`endif
    held_diff = ed;
    held_bout = eb;
  endtask

  initial begin
    int pulses;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    held_diff = '0; held_bout = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset diff", 64'(diff), 64'(0));
    chk("reset b_out", 64'(b_out), 64'(0));
`ifdef SERIAL_SUB_OVF_EN
    chk("reset ovf", 64'(ovf), 64'(0));
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'h05, 8'h03, 1'b0, -1, "5-3");
    @(posedge clk); #1;
    chk("done single", 64'(done), 64'(0));
    run_op(8'h03, 8'h05, 1'b0, -1, "3-5");
    run_op(8'h00, 8'h00, 1'b1, -1, "0-0-1");
    run_op(8'hFF, 8'hFF, 1'b0, -1, "b2b FF-FF");

    run_op(8'h10, 8'h01, 1'b0, 3, "repulse");
    @(posedge clk); #1;
    chk("repulse done_once", 64'(done), 64'(0));
    chk("repulse idle", 64'(busy), 64'(0));

    run_op(8'h80, 8'h01, 1'b0, -1, "80-01");
    run_op(8'h7F, 8'hFF, 1'b0, -1, "7F-FF");

    // Abort by reset sampled on the fourth edge of RUN.
    a = 8'h55; b = 8'h11; b_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    chk("abort diff", 64'(diff), 64'(0));
    chk("abort b_out", 64'(b_out), 64'(0));
    held_diff = '0; held_bout = 1'b0;
    pulses = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    chk("abort no_done", 64'(pulses), 64'(0));
    run_op(8'h3C, 8'h0F, 1'b0, -1, "after_abort");

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      run_op(ra, rb, rc, -1, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
